// File: rtl/pin_pattern_gen.sv
// rtl/pin_pattern_gen.sv - board bring-up pin pattern generator with loopback checker
module pin_pattern_gen #(
    parameter int WIDTH    = 8,
    parameter int DIV_BITS = 20,
    parameter bit INVERT   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          mode,
    input  logic [DIV_BITS-1:0] period,
    input  logic                check_en,
    input  logic                clear_err,
    input  logic [WIDTH-1:0]    pins_in,
    output logic [WIDTH-1:0]    pins_out,
    output logic                step,
    output logic                wrap,
    output logic [WIDTH-1:0]    fail_mask,
    output logic [15:0]         err_count
);

    localparam logic [1:0] MODE_WALK1  = 2'd0;
    localparam logic [1:0] MODE_WALK0  = 2'd1;
    localparam logic [1:0] MODE_COUNT  = 2'd2;
    localparam logic [1:0] MODE_TOGGLE = 2'd3;

    localparam logic [WIDTH-1:0] PAT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] PAT_ONES = {WIDTH{1'b1}};
    localparam logic [15:0]      ERR_MAX  = 16'hFFFF;

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]    pat_q, pat_d;
    logic [1:0]          mode_q, mode_d;
    logic                step_q, step_d;
    logic                wrap_q, wrap_d;
    logic [WIDTH-1:0]    fail_mask_q, fail_mask_d;
    logic [15:0]         err_count_q, err_count_d;

    logic [WIDTH-1:0]    pat_adv;
    logic [WIDTH-1:0]    diff;

    function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
        case (m)
            MODE_WALK1: seed_of = PAT_ONE;
            MODE_WALK0: seed_of = ~PAT_ONE;
            default:    seed_of = '0;
        endcase
    endfunction

    assign pins_out  = INVERT ? ~pat_q : pat_q;
    assign step      = step_q;
    assign wrap      = wrap_q;
    assign fail_mask = fail_mask_q;
    assign err_count = err_count_q;
    assign diff      = pins_in ^ pins_out;

    // Walking patterns self-heal if the register ever loses its single odd bit.
    always_comb begin
        pat_adv = pat_q;
        case (mode_q)
            MODE_WALK1:  pat_adv = (pat_q == '0) ? PAT_ONE
                                 : {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            MODE_WALK0:  pat_adv = (pat_q == PAT_ONES) ? ~PAT_ONE
                                 : {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            MODE_COUNT:  pat_adv = pat_q + PAT_ONE;
            MODE_TOGGLE: pat_adv = ~pat_q;
            default:     pat_adv = pat_q;
        endcase
    end

    always_comb begin
        mode_d      = mode;
        cnt_d       = cnt_q;
        pat_d       = pat_q;
        step_d      = 1'b0;
        wrap_d      = 1'b0;
        fail_mask_d = fail_mask_q;
        err_count_d = err_count_q;

        if (mode != mode_q) begin
            pat_d = seed_of(mode);
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == period) begin
                cnt_d  = '0;
                pat_d  = pat_adv;
                step_d = 1'b1;
                wrap_d = (pat_adv == seed_of(mode_q));
                if (check_en) begin
                    fail_mask_d = fail_mask_q | diff;
                    if (diff != '0 && err_count_q != ERR_MAX) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (clear_err) begin
            fail_mask_d = '0;
            err_count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= '0;
            pat_q       <= PAT_ONE;
            mode_q      <= MODE_WALK1;
            step_q      <= 1'b0;
            wrap_q      <= 1'b0;
            fail_mask_q <= '0;
            err_count_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            pat_q       <= pat_d;
            mode_q      <= mode_d;
            step_q      <= step_d;
            wrap_q      <= wrap_d;
            fail_mask_q <= fail_mask_d;
            err_count_q <= err_count_d;
        end
    end

endmodule

// File: tb/tb_pin_pattern_gen.sv
// tb/tb_pin_pattern_gen.sv - scoreboard bench for pin_pattern_gen
module tb_pin_pattern_gen;

    localparam bit INV = 1'b1;

    logic        clk = 1'b0;
    logic        reset, enable, check_en, clear_err;
    logic [1:0]  mode;
    logic [19:0] period;
    logic [7:0]  xor_mask;
    logic [7:0]  pins_in, pins_out, fail_mask, obs_pat;
    logic        step, wrap;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    assign pins_in = pins_out ^ xor_mask;
    assign obs_pat = ~pins_out;

    pin_pattern_gen #(.WIDTH(8), .DIV_BITS(20), .INVERT(INV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .period(period),
        .check_en(check_en), .clear_err(clear_err), .pins_in(pins_in),
        .pins_out(pins_out), .step(step), .wrap(wrap),
        .fail_mask(fail_mask), .err_count(err_count)
    );

    typedef struct packed {
        logic [7:0]  po;
        logic        st;
        logic        wr;
        logic [7:0]  mask;
        logic [15:0] err;
    } exp_t;

    exp_t sb[$];

    logic [19:0] m_cnt;
    logic [7:0]  m_pat, m_mask;
    logic [1:0]  m_mode;
    logic        m_step, m_wrap;
    logic [15:0] m_err;

    int n_checks = 0;
    int n_pass   = 0;
    int nstep, nwrap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    function automatic logic [7:0] seed(input logic [1:0] m);
        return (m == 2'd0) ? 8'h01 : (m == 2'd1) ? 8'hFE : 8'h00;
    endfunction

    task automatic model_step();
        logic [7:0] drv, nx, d;
        drv = INV ? ~m_pat : m_pat;
        if (reset) begin
            m_cnt = 0; m_pat = 8'h01; m_mode = 0;
            m_step = 0; m_wrap = 0; m_mask = 0; m_err = 0;
            return;
        end
        m_step = 0;
        m_wrap = 0;
        if (mode != m_mode) begin
            m_pat = seed(mode);
            m_cnt = 0;
        end else if (enable) begin
            if (m_cnt == period) begin
                if (check_en) begin
                    d = (drv ^ xor_mask) ^ drv;
                    m_mask = m_mask | d;
                    if (d != 0 && m_err < 16'hFFFF) m_err = m_err + 1;
                end
                case (m_mode)
                    2'd0: nx = (m_pat == 0) ? 8'h01 : ((m_pat << 1) | (m_pat >> 7));
                    2'd1: nx = (m_pat == 8'hFF) ? 8'hFE : ((m_pat << 1) | (m_pat >> 7));
                    2'd2: nx = m_pat + 8'd1;
                    default: nx = m_pat ^ 8'hFF;
                endcase
                m_pat  = nx;
                m_step = 1;
                m_wrap = (nx == seed(m_mode));
                m_cnt  = 0;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (clear_err) begin
            m_mask = 0;
            m_err  = 0;
        end
        m_mode = mode;
    endtask

    task automatic cycle();
        exp_t e, got;
        model_step();
        e.po = INV ? ~m_pat : m_pat;
        e.st = m_step; e.wr = m_wrap; e.mask = m_mask; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("sb_pins_out",  pins_out,  got.po);
        check("sb_step",      step,      got.st);
        check("sb_wrap",      wrap,      got.wr);
        check("sb_fail_mask", fail_mask, got.mask);
        check("sb_err_count", err_count, got.err);
    endtask

    initial begin
        reset = 1; enable = 0; mode = 0; period = 3;
        check_en = 0; clear_err = 0; xor_mask = 0;
        repeat (2) cycle();
        check("rst_pins_out", pins_out, 8'hFE);
        check("rst_step", step, 0);
        check("rst_err", err_count, 0);

        // walk-one, period 3, clean loopback
        reset = 0; enable = 1; check_en = 1;
        nstep = 0; nwrap = 0;
        repeat (36) begin cycle(); nstep += step; nwrap += wrap; end
        check("w1_steps", nstep, 9);
        check("w1_wraps", nwrap, 1);
        check("w1_pat", obs_pat, 8'h02);
        check("w1_mask", fail_mask, 0);

        // walk-zero seeded straight out of reset
        reset = 1; mode = 1; cycle();
        reset = 0; cycle();
        check("w0_reload_pins", pins_out, 8'h01);
        check("w0_reload_step", step, 0);
        period = 0;
        repeat (7) cycle();
        check("w0_no_wrap_yet", wrap, 0);
        cycle();
        check("w0_wrap", wrap, 1);
        check("w0_pat_back", obs_pat, 8'hFE);

        // count-up with an enable gap
        mode = 2; cycle();
        check("cnt_seed", obs_pat, 8'h00);
        check("cnt_seed_step", step, 0);
        repeat (100) cycle();
        enable = 0;
        repeat (5) begin
            cycle();
            check("cnt_hold_step", step, 0);
            check("cnt_hold_pat", obs_pat, 8'h64);
        end
        enable = 1;
        nwrap = 0;
        repeat (200) begin cycle(); nwrap += wrap; end
        check("cnt_wraps", nwrap, 1);
        check("cnt_pat", obs_pat, 8'h2C);

        // stuck-bit loopback and clear priority
        mode = 0; period = 1; xor_mask = 8'h10; clear_err = 1; cycle();
        clear_err = 0;
        repeat (6) cycle();
        check("lb_mask", fail_mask, 8'h10);
        check("lb_err", err_count, 3);
        cycle();
        clear_err = 1; cycle();
        check("lb_clear_tick", step, 1);
        check("lb_clear_mask", fail_mask, 0);
        check("lb_clear_err", err_count, 0);
        clear_err = 0;

        // error counter saturation
        period = 0;
        repeat (65534) cycle();
        check("sat_fffe", err_count, 16'hFFFE);
        repeat (3) cycle();
        check("sat_ffff", err_count, 16'hFFFF);

        // mode switch mid-walk, toggle, then reset mid-sequence
        xor_mask = 0; clear_err = 1; cycle();
        clear_err = 0;
        for (int i = 0; i < 16; i++) begin
            if (obs_pat == 8'h08) break;
            cycle();
        end
        check("walk_at_08", obs_pat, 8'h08);
        mode = 3; xor_mask = 8'h10; cycle();
        check("tg_seed", obs_pat, 8'h00);
        check("tg_seed_step", step, 0);
        cycle();
        check("tg_ff", obs_pat, 8'hFF);
        check("tg_ff_wrap", wrap, 0);
        cycle();
        check("tg_00", obs_pat, 8'h00);
        check("tg_00_wrap", wrap, 1);
        cycle();
        check("tg_ff2", obs_pat, 8'hFF);
        check("tg_mask", fail_mask, 8'h10);
        reset = 1; clear_err = 1; cycle();
        check("mid_rst_pins", pins_out, 8'hFE);
        check("mid_rst_step", step, 0);
        check("mid_rst_wrap", wrap, 0);
        check("mid_rst_mask", fail_mask, 0);
        check("mid_rst_err", err_count, 0);
        reset = 0; clear_err = 0;
        repeat (3) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pin_pattern_gen.md
Name: pin_pattern_gen

Overview:
Parametrised board-bring-up pattern generator and loopback checker, the next generation of the FPGA pin-test logic. It drives a WIDTH-bit output bus with a selectable test pattern (walking one, walking zero, binary count, all-toggle) that advances at a programmable rate. It optionally compares a looped-back input bus against the driven value, accumulating a sticky per-bit fail mask and a saturating error count. One instance is placed per pin group (CPU bus, SDRAM, VRAM, expansion header).

Parameters:
WIDTH, 8, number of pattern bits / pins driven and checked (>=2)
DIV_BITS, 20, width of the step-period register
INVERT, 1, 1 = pins_out driven inverted (~pattern), 0 = driven true

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
enable  input  1  1 = prescaler runs, pattern advances, checks active
mode  input  2  0 walk-one, 1 walk-zero, 2 count-up, 3 toggle-all
period  input  DIV_BITS  step every period+1 clocks
check_en  input  1  enables loopback comparison
clear_err  input  1  clears fail_mask and err_count
pins_in  input  WIDTH  looped-back pin values
pins_out  output  WIDTH  driven pattern (post-INVERT)
step  output  1  one-cycle pulse when the pattern advances
wrap  output  1  one-cycle pulse when the pattern returns to its mode seed
fail_mask  output  WIDTH  sticky OR of mismatching bits
err_count  output  16  number of mismatching steps, saturates at 16'hFFFF

Behaviour:
- Everything is synchronous to clk. Reset (synchronous, active-high) takes priority over all other inputs.
- Reset values: cnt=0, pat=1 (walk-one seed), mode_q=0, step=0, wrap=0, fail_mask=0, err_count=0. pins_out = INVERT ? ~1 : 1.
- Seeds per mode: walk-one = 1; walk-zero = ~1 (all ones except bit0); count-up = 0; toggle-all = 0.
- Prescaler: while enable=1, cnt increments. When cnt==period, the cycle is a tick: cnt<=0 and step is registered high for the next cycle. With period=0, every enabled cycle is a tick. The period input is sampled live; if it drops below cnt, cnt continues to its all-ones wrap and rolls over to 0. No tick is issued until cnt==period again.
- enable=0: cnt, pat and the error state all hold; step=0, wrap=0; no checking.
- Mode change: mode_q registers mode every cycle. If mode != mode_q, the next edge loads the new seed into pat and clears cnt. This has priority over a tick in that cycle, and no step or wrap is issued. The same applies after reset if mode != 0.
- Advance on tick:
  - walk-one: rotate left. If pat==0, reload 1.
  - walk-zero: rotate left. If pat is all ones, reload ~1.
  - count-up: pat+1, modulo 2^WIDTH.
  - toggle-all: pat <= ~pat.
- wrap is registered high together with step when the new pat equals the mode seed:
  - walk-one / walk-zero: every WIDTH ticks.
  - count-up: all ones -> 0.
  - toggle-all: every 2nd tick.
- pins_out is combinational from pat: INVERT ? ~pat : pat. This gives zero latency from pat and introduces no extra register.
- Check: performed on tick cycles with enable=1 and check_en=1, before pat updates. It compares pins_in against the current pins_out.
  - diff = pins_in ^ pins_out.
  - fail_mask |= diff.
  - If diff != 0, err_count += 1, saturating at 16'hFFFF (holds there).
- clear_err=1: fail_mask<=0 and err_count<=0. This takes priority over a same-cycle mismatch, which is discarded. It does not affect pattern or prescaler.
- Reset asserted mid-sequence: the next edge restores every reset value regardless of enable, mode or clear_err.

Test Plan:
- WIDTH=8, INVERT=0, mode=0, period=3, enable=1, pins_in tied to pins_out -> pins_out steps 01,02,04,...,80,01 every 4 clocks. step pulses every 4th cycle; wrap accompanies the 80->01 step. fail_mask=00, err_count=0.
- mode=1 after reset, INVERT=1 -> one cycle after reset release, pat=FE and pins_out=01. No step on the reload cycle. After 8 ticks, wrap=1 and pat=FE again.
- mode=2, period=0 -> pat increments every cycle. wrap fires on FF->00, 256 cycles after seed. Drop enable for 5 cycles mid-count: pat and cnt hold, step=0.
- Loopback with pins_in = pins_out ^ 8'h10, mode=0, period=1 -> after 3 ticks, fail_mask=10 and err_count=3. Assert clear_err together with a mismatching tick: fail_mask=00, err_count=0.
- Force err_count to 16'hFFFE via 65534 mismatching ticks (period=0), then 3 more -> err_count holds at FFFF.
- Switch mode 0->3 mid-walk at pat=08 -> next edge gives pat=00, cnt=0 with no step. Ticks then give FF,00,FF with wrap on each return to 00. Assert reset mid-sequence -> pat=01, all counters and flags 0 on the next edge.
